regfile_scoreboard: RTL

Parametrised multi-port integer register file for the NPC pipeline, with per-register busy (scoreboard) bits. Provides NR_READ registered read ports, NR_WRITE write ports, same-cycle write-to-read bypass, and an optional hard-wired zero register. Sits between decode/issue (reads, busy set) and writeback (writes, busy clear). Flush support discards in-flight destinations.

---
 rtl/regfile_scoreboard_pkg.sv | 13 +
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard_busy.sv | 74 +++++++
 rtl/regfile_scoreboard.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file / scoreboard slice.
//   DEF_ADDR_WIDTH : default register index width (depth = 2**width)
//   DEF_DATA_WIDTH : default register data width
//   REG_ZERO       : index of the optional hard-wired zero register
package regfile_scoreboard_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NR_READ    = 2;
  localparam int DEF_NR_WRITE   = 2;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
//   raddr/rdata/rbusy         : read ports, port i packed at [i*W +: W]
//   wen/waddr/wdata/wclr      : writeback ports with optional busy clear
//   iss_en/iss_rd             : issue marks a destination busy
//   flush                     : clear every busy bit
//   busy_cnt                  : number of busy registers
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_READ    = DEF_NR_READ,
  parameter int NR_WRITE   = DEF_NR_WRITE
);

  logic [NR_READ*ADDR_WIDTH-1:0]  raddr;
  logic [NR_READ*DATA_WIDTH-1:0]  rdata;
  logic [NR_READ-1:0]             rbusy;
  logic [NR_WRITE-1:0]            wen;
  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr;
  logic [NR_WRITE*DATA_WIDTH-1:0] wdata;
  logic [NR_WRITE-1:0]            wclr;
  logic                           iss_en;
  logic [ADDR_WIDTH-1:0]          iss_rd;
  logic                           flush;
  logic [ADDR_WIDTH:0]            busy_cnt;

  modport master (
    output raddr, wen, waddr, wdata, wclr, iss_en, iss_rd, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, wen, waddr, wdata, wclr, iss_en, iss_rd, flush,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard_busy.sv
// Scoreboard: one busy bit per register.
// Priority per register: flush clears, issue sets, writeback clear clears.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   raddr               : read addresses (packed)
//   wen, waddr, wclr    : writeback ports; clear only counts with wen
//   iss_en, iss_rd      : issue sets busy
//   flush               : clear all busy bits
//   rbusy               : registered busy of each read address (post-update)
//   busy_cnt            : registered popcount of the post-update busy vector
module regfile_scoreboard_busy
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_READ    = DEF_NR_READ,
  parameter int NR_WRITE   = DEF_NR_WRITE,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr,
  input  logic [NR_WRITE-1:0]            wen,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WRITE-1:0]            wclr,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  input  logic                           flush,
  output logic [NR_READ-1:0]             rbusy,
  output logic [ADDR_WIDTH:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_next;
  logic [ADDR_WIDTH:0] cnt_next;

  // Applied lowest priority first so later statements override earlier ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    busy_next = busy;
    for (int j = 0; j < NR_WRITE; j++) begin
      if (wen[j] && wclr[j]) busy_next[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (iss_en) busy_next[iss_rd] = 1'b1;
    if (flush)  busy_next = '0;
    if (ZERO_REG != 0) busy_next[REG_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int r = 0; r < DEPTH; r++) begin
      // NOTE: blocking '=' is correct in combinational code (the running sum
      // must see its own previous value); registers below use '<=' only.
      cnt_next = cnt_next + (ADDR_WIDTH+1)'(busy_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      rbusy    <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      for (int i = 0; i < NR_READ; i++) begin
        rbusy[i] <= busy_next[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-first bypass, optional
// hard-wired zero register and per-register busy (scoreboard) bits.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_scoreboard_if (read, write, issue,
//              flush, busy_cnt); read data and busy flags have 1-cycle latency
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_READ    = DEF_NR_READ,
  parameter int NR_WRITE   = DEF_NR_WRITE,
  parameter int ZERO_REG   = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_scoreboard_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [ADDR_WIDTH-1:0] ra [NR_READ];
  logic [ADDR_WIDTH-1:0] wa [NR_WRITE];
  logic [DATA_WIDTH-1:0] wd [NR_WRITE];
  logic [DATA_WIDTH-1:0] rd_val [NR_READ];
  logic [NR_READ*DATA_WIDTH-1:0] rdata_q;
  logic [NR_READ-1:0]            rbusy;
  logic [ADDR_WIDTH:0]           busy_cnt;

  for (genvar i = 0; i < NR_READ; i++) begin : g_ra
    assign ra[i] = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end
  for (genvar j = 0; j < NR_WRITE; j++) begin : g_wa
    assign wa[j] = bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[j] = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
  end

  // Write-first bypass: a matching write this edge replaces the array value;
  // scanning ports upward makes the highest enabled port win, matching the
  // array write below. wen gates the compare so an idle port's address is
  // never looked at.
  always_comb begin
    for (int i = 0; i < NR_READ; i++) begin
      rd_val[i] = rf[ra[i]];
      for (int j = 0; j < NR_WRITE; j++) begin
        if (bus.wen[j] && (wa[j] == ra[i])) rd_val[i] = wd[j];
      end
      if ((ZERO_REG != 0) && (ra[i] == ZERO_ADDR)) rd_val[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset because software relies on all-zero
      // registers after reset; this rules out mapping it to a RAM macro.
      for (int r = 0; r < DEPTH; r++) rf[r] <= '0;
      rdata_q <= '0;
    end else begin
      // Later non-blocking writes to the same entry win: higher port index.
      for (int j = 0; j < NR_WRITE; j++) begin
        if (bus.wen[j] && !((ZERO_REG != 0) && (wa[j] == ZERO_ADDR))) rf[wa[j]] <= wd[j];
      end
      for (int i = 0; i < NR_READ; i++) rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val[i];
    end
  end

  regfile_scoreboard_busy #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_READ    (NR_READ),
    .NR_WRITE   (NR_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .raddr    (bus.raddr),
    .wen      (bus.wen),
    .waddr    (bus.waddr),
    .wclr     (bus.wclr),
    .iss_en   (bus.iss_en),
    .iss_rd   (bus.iss_rd),
    .flush    (bus.flush),
    .rbusy    (rbusy),
    .busy_cnt (busy_cnt)
  );

  assign bus.rdata    = rdata_q;
  assign bus.rbusy    = rbusy;
  assign bus.busy_cnt = busy_cnt;

endmodule
